// File: rtl/wb_stage_nlane.sv
// N-lane MEM->WB register with in-order exception resolution and retire counter.
// Latency 1 cycle MEM->WB; holds when downstream stalls, and a flush drops the bundle being loaded.
module wb_stage_nlane #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int RA_W    = 5,
  parameter int ECODE_W = 6
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               next_allowin_i,
  input  logic [LANES-1:0]                                   pre_valid_i,
  output logic                                               now_allowin_o,
  input  logic [LANES*(2*PC_W+DATA_W+RA_W+ECODE_W+2)-1:0]    pre_bus_i,
  output logic [LANES-1:0]                                   rf_we_o,
  output logic [LANES*RA_W-1:0]                              rf_waddr_o,
  output logic [LANES*DATA_W-1:0]                            rf_wdata_o,
  output logic [LANES*PC_W-1:0]                              dbg_pc_o,
  output logic [LANES-1:0]                                   dbg_valid_o,
  output logic                                               excp_flush_o,
  output logic [$clog2(LANES):0]                             excp_lane_o,
  output logic [PC_W-1:0]                                    excp_pc_o,
  output logic [ECODE_W-1:0]                                 excp_ecode_o,
  output logic [PC_W-1:0]                                    excp_badv_o,
  output logic [63:0]                                        retired_cnt_o
);

  localparam int LW = 2*PC_W + DATA_W + RA_W + ECODE_W + 2;
  localparam int EW = $clog2(LANES) + 1;

  typedef struct packed {
    logic [PC_W-1:0]    badv;
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  wdata;
    logic [RA_W-1:0]    waddr;
    logic [ECODE_W-1:0] ecode;
    logic               excp;
    logic               we;
  } lane_t;

  logic [LANES-1:0]    lane_valid;
  logic [LANES*LW-1:0] bus_q;
  lane_t               ln [LANES];
  logic                win_found;
  logic [EW-1:0]       win;
  logic [LANES-1:0]    retire;
  logic [63:0]         pop;

  assign now_allowin_o = !(|lane_valid) || next_allowin_i;

  always_comb begin
    win_found    = 1'b0;
    win          = '0;
    retire       = '0;
    pop          = '0;
    rf_we_o      = '0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    dbg_pc_o     = '0;
    dbg_valid_o  = '0;
    excp_pc_o    = '0;
    excp_ecode_o = '0;
    excp_badv_o  = '0;
    for (int j = 0; j < LANES; j++) begin
      ln[j] = lane_t'(bus_q[j*LW +: LW]);
    end
    // Lane 0 is oldest, so the first excepting lane found wins.
    for (int j = 0; j < LANES; j++) begin
      if (!win_found && lane_valid[j] && ln[j].excp) begin
        win_found    = 1'b1;
        win          = EW'(j);
        excp_pc_o    = ln[j].pc;
        excp_ecode_o = ln[j].ecode;
        excp_badv_o  = ln[j].badv;
      end
    end
    excp_lane_o  = win;
    excp_flush_o = win_found && next_allowin_i;
    for (int j = 0; j < LANES; j++) begin
      retire[j]      = lane_valid[j] && next_allowin_i && (!win_found || (EW'(j) < win));
      rf_we_o[j]     = retire[j] && ln[j].we;
      dbg_valid_o[j] = retire[j];
      if (lane_valid[j]) begin
        rf_waddr_o[j*RA_W +: RA_W]     = ln[j].waddr;
        rf_wdata_o[j*DATA_W +: DATA_W] = ln[j].wdata;
        dbg_pc_o[j*PC_W +: PC_W]       = ln[j].pc;
      end
      pop = pop + 64'(retire[j]);
    end
  end

  // Payload needs no reset: every output derived from it is masked by lane_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_valid <= '0;
    end else if (excp_flush_o) begin
      lane_valid <= '0;
    end else if (now_allowin_o) begin
      lane_valid <= pre_valid_i;
      bus_q      <= pre_bus_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) retired_cnt_o <= '0;
    else     retired_cnt_o <= retired_cnt_o + pop;
  end

endmodule

// File: tb/tb_wb_stage_nlane.sv
// Directed bench for wb_stage_nlane: a 2-lane and a 4-lane instance driven in turn.
module tb_wb_stage_nlane;

  localparam int LW = 109;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2-lane instance
  logic            rst2, next2, now2, flush2;
  logic [1:0]      pv2, we2, dv2, lane2;
  logic [2*LW-1:0] bus2;
  logic [9:0]      waddr2;
  logic [63:0]     wdata2, dpc2, cnt2;
  logic [31:0]     epc2, ebadv2;
  logic [5:0]      ecode2;

  // 4-lane instance
  logic            rst4, next4, now4, flush4;
  logic [3:0]      pv4, we4, dv4;
  logic [2:0]      lane4;
  logic [4*LW-1:0] bus4;
  logic [19:0]     waddr4;
  logic [127:0]    wdata4, dpc4;
  logic [63:0]     cnt4;
  logic [31:0]     epc4, ebadv4;
  logic [5:0]      ecode4;

  wb_stage_nlane #(.LANES(2)) u2 (
    .clk(clk), .rst(rst2), .next_allowin_i(next2), .pre_valid_i(pv2), .now_allowin_o(now2),
    .pre_bus_i(bus2), .rf_we_o(we2), .rf_waddr_o(waddr2), .rf_wdata_o(wdata2),
    .dbg_pc_o(dpc2), .dbg_valid_o(dv2), .excp_flush_o(flush2), .excp_lane_o(lane2),
    .excp_pc_o(epc2), .excp_ecode_o(ecode2), .excp_badv_o(ebadv2), .retired_cnt_o(cnt2)
  );

  wb_stage_nlane #(.LANES(4)) u4 (
    .clk(clk), .rst(rst4), .next_allowin_i(next4), .pre_valid_i(pv4), .now_allowin_o(now4),
    .pre_bus_i(bus4), .rf_we_o(we4), .rf_waddr_o(waddr4), .rf_wdata_o(wdata4),
    .dbg_pc_o(dpc4), .dbg_valid_o(dv4), .excp_flush_o(flush4), .excp_lane_o(lane4),
    .excp_pc_o(epc4), .excp_ecode_o(ecode4), .excp_badv_o(ebadv4), .retired_cnt_o(cnt4)
  );

  function automatic logic [LW-1:0] mk(input logic [31:0] badv, input logic [31:0] pc,
                                       input logic [31:0] wdata, input logic [4:0] waddr,
                                       input logic [5:0] ecode, input logic excp, input logic we);
    return {badv, pc, wdata, waddr, ecode, excp, we};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst2 = 1'b1; next2 = 1'b1; pv2 = '0; bus2 = '0;
    rst4 = 1'b1; next4 = 1'b1; pv4 = '0; bus4 = '0;
    tick(); tick();
    rst2 = 1'b0; rst4 = 1'b0;
    #1;
    chk("rst_we",     64'(we2),    64'd0);
    chk("rst_dv",     64'(dv2),    64'd0);
    chk("rst_flush",  64'(flush2), 64'd0);
    chk("rst_lane",   64'(lane2),  64'd0);
    chk("rst_epc",    64'(epc2),   64'd0);
    chk("rst_wdata",  wdata2,      64'd0);
    chk("rst_cnt",    cnt2,        64'd0);
    chk("rst_allow",  64'(now2),   64'd1);

    // A: two clean writes
    pv2  = 2'b11;
    bus2 = {mk(0, 32'h1C000004, 32'h22, 5'd7, 6'h0, 1'b0, 1'b1),
            mk(0, 32'h1C000000, 32'h11, 5'd3, 6'h0, 1'b0, 1'b1)};
    tick();
    // B: lane 1 excepts
    pv2  = 2'b11;
    bus2 = {mk(32'hDEAD0000, 32'h1C000004, 32'h44, 5'd9, 6'h0B, 1'b1, 1'b1),
            mk(0,            32'h1C000008, 32'h33, 5'd4, 6'h00, 1'b0, 1'b1)};
    chk("a_we",    64'(we2),   64'h3);
    chk("a_dv",    64'(dv2),   64'h3);
    chk("a_waddr", 64'(waddr2), 64'h0E3);
    chk("a_wdata", wdata2,     64'h00000022_00000011);
    chk("a_dpc",   dpc2,       64'h1C000004_1C000000);
    chk("a_flush", 64'(flush2), 64'd0);
    chk("a_cnt",   cnt2,       64'd0);
    tick();
    // C: arrives during the flush cycle and must be dropped
    pv2  = 2'b11;
    bus2 = {mk(0, 32'h1C00000C, 32'h66, 5'd1, 6'h0, 1'b0, 1'b1),
            mk(0, 32'h1C000008, 32'h55, 5'd2, 6'h0, 1'b0, 1'b1)};
    chk("b_cnt",   cnt2,        64'd2);
    chk("b_we",    64'(we2),    64'h1);
    chk("b_dv",    64'(dv2),    64'h1);
    chk("b_flush", 64'(flush2), 64'd1);
    chk("b_lane",  64'(lane2),  64'd1);
    chk("b_epc",   64'(epc2),   64'h1C000004);
    chk("b_ecode", 64'(ecode2), 64'h0B);
    chk("b_badv",  64'(ebadv2), 64'hDEAD0000);
    chk("b_allow", 64'(now2),   64'd1);
    tick();
    chk("c_dv",    64'(dv2),    64'd0);
    chk("c_we",    64'(we2),    64'd0);
    chk("c_flush", 64'(flush2), 64'd0);
    chk("c_wdata", wdata2,      64'd0);
    chk("c_cnt",   cnt2,        64'd3);

    // D: both lanes except, oldest wins
    pv2  = 2'b11;
    bus2 = {mk(32'h200, 32'h1C000014, 0, 5'd0, 6'h0B, 1'b1, 1'b1),
            mk(32'h100, 32'h1C000010, 0, 5'd0, 6'h08, 1'b1, 1'b1)};
    tick();
    pv2 = 2'b00;
    chk("d_lane",  64'(lane2),  64'd0);
    chk("d_ecode", 64'(ecode2), 64'h08);
    chk("d_epc",   64'(epc2),   64'h1C000010);
    chk("d_badv",  64'(ebadv2), 64'h100);
    chk("d_we",    64'(we2),    64'd0);
    chk("d_dv",    64'(dv2),    64'd0);
    chk("d_flush", 64'(flush2), 64'd1);
    tick();
    chk("d_cnt",    cnt2,        64'd3);
    chk("d_flush2", 64'(flush2), 64'd0);

    // E: lane 0 excepting under a 3-cycle stall
    pv2  = 2'b01;
    bus2 = {mk(0, 0, 0, 5'd0, 6'h0, 1'b0, 1'b0),
            mk(32'h44, 32'h1C000020, 0, 5'd0, 6'h05, 1'b1, 1'b0)};
    tick();
    next2 = 1'b0;
    pv2   = 2'b11;
    bus2  = {mk(0, 32'h1C000004, 32'h22, 5'd7, 6'h0, 1'b0, 1'b1),
             mk(0, 32'h1C000000, 32'h11, 5'd3, 6'h0, 1'b0, 1'b1)};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("e_stall_flush", 64'(flush2), 64'd0);
      chk("e_stall_allow", 64'(now2),   64'd0);
      chk("e_stall_ecode", 64'(ecode2), 64'h05);
      chk("e_stall_dv",    64'(dv2),    64'd0);
      tick();
    end
    next2 = 1'b1;
    #1;
    chk("e_flush", 64'(flush2), 64'd1);
    chk("e_lane",  64'(lane2),  64'd0);
    chk("e_allow", 64'(now2),   64'd1);
    tick();
    pv2 = 2'b00;
    chk("e_flush_once", 64'(flush2), 64'd0);
    chk("e_dv",         64'(dv2),    64'd0);
    chk("e_cnt",        cnt2,        64'd3);

    // 4 lanes: counter wrap
    force u4.retired_cnt_o = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release u4.retired_cnt_o;
    pv4  = 4'b1111;
    bus4 = {mk(0, 32'h2000000C, 32'hA3, 5'd4, 6'h0, 1'b0, 1'b0),
            mk(0, 32'h20000008, 32'hA2, 5'd3, 6'h0, 1'b0, 1'b1),
            mk(0, 32'h20000004, 32'hA1, 5'd2, 6'h0, 1'b0, 1'b0),
            mk(0, 32'h20000000, 32'hA0, 5'd1, 6'h0, 1'b0, 1'b1)};
    tick();
    pv4 = 4'b0000;
    chk("w_we",    64'(we4),    64'h5);
    chk("w_dv",    64'(dv4),    64'hF);
    chk("w_waddr", 64'(waddr4), 64'h20C41);
    chk("w_cnt0",  cnt4,        64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("w_cnt",   cnt4,        64'd2);

    // 4 lanes: lane 2 excepts, lanes 0-1 retire, lane 3 squashed
    pv4  = 4'b1111;
    bus4 = {mk(0,      32'h2000001C, 32'hB3, 5'd8, 6'h00, 1'b0, 1'b1),
            mk(32'h77, 32'h20000018, 32'hB2, 5'd7, 6'h0C, 1'b1, 1'b1),
            mk(0,      32'h20000014, 32'hB1, 5'd6, 6'h00, 1'b0, 1'b1),
            mk(0,      32'h20000010, 32'hB0, 5'd5, 6'h00, 1'b0, 1'b1)};
    tick();
    pv4 = 4'b0000;
    chk("m_we",    64'(we4),    64'h3);
    chk("m_dv",    64'(dv4),    64'h3);
    chk("m_lane",  64'(lane4),  64'd2);
    chk("m_ecode", 64'(ecode4), 64'h0C);
    chk("m_epc",   64'(epc4),   64'h20000018);
    chk("m_flush", 64'(flush4), 64'd1);
    tick();
    chk("m_cnt",    cnt4,        64'd4);
    chk("m_flush2", 64'(flush4), 64'd0);

    // 4 lanes: reset during a stall
    pv4  = 4'b1111;
    bus4 = {mk(0, 32'h3000000C, 32'hC3, 5'd4, 6'h0, 1'b0, 1'b1),
            mk(0, 32'h30000008, 32'hC2, 5'd3, 6'h0, 1'b0, 1'b1),
            mk(0, 32'h30000004, 32'hC1, 5'd2, 6'h0, 1'b0, 1'b1),
            mk(0, 32'h30000000, 32'hC0, 5'd1, 6'h0, 1'b0, 1'b1)};
    tick();
    next4 = 1'b0;
    pv4   = 4'b0000;
    #1;
    chk("s_allow", 64'(now4), 64'd0);
    chk("s_dv",    64'(dv4),  64'd0);
    tick();
    rst4 = 1'b1;
    tick();
    rst4  = 1'b0;
    next4 = 1'b1;
    #1;
    chk("r_dv",    64'(dv4),  64'd0);
    chk("r_we",    64'(we4),  64'd0);
    chk("r_cnt",   cnt4,      64'd0);
    chk("r_allow", 64'(now4), 64'd1);
    tick();
    chk("r_cnt2",  cnt4,      64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_nlane.md
Name: wb_stage_nlane

Overview:
- Parametrised N-lane writeback stage; successor to the dual-issue WB stage, between the MEM stage and the register file / CSR unit.
- Contains the MEM->WB pipeline register for all lanes.
- Resolves in-order exception priority: the oldest excepting lane wins, and all younger lanes are squashed.
- Emits per-lane regfile write ports, a debug trace, a single exception bundle and flush, and a 64-bit retired-instruction counter.

Parameters:
LANES, 2, number of issue lanes (1..4); lane 0 is oldest in program order
DATA_W, 32, register data width
PC_W, 32, PC / bad-address width
RA_W, 5, register address width
ECODE_W, 6, exception code width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
next_allowin_i  in  1  downstream (regfile/commit) can accept
pre_valid_i  in  LANES  per-lane valid from MEM
now_allowin_o  out  1  WB register can load this cycle
pre_bus_i  in  LANES*(2*PC_W+DATA_W+RA_W+ECODE_W+2)  per lane {badv,pc,wdata,waddr,ecode,excp,we}; lane 0 in LSBs
rf_we_o  out  LANES  per-lane regfile write enable, masked
rf_waddr_o  out  LANES*RA_W  write addresses
rf_wdata_o  out  LANES*DATA_W  write data
dbg_pc_o  out  LANES*PC_W  debug trace PC
dbg_valid_o  out  LANES  lane retired this cycle
excp_flush_o  out  1  pipeline flush, combinational from WB register
excp_lane_o  out  $clog2(LANES)+1  winning lane index
excp_pc_o  out  PC_W  PC of winning lane
excp_ecode_o  out  ECODE_W  ecode of winning lane
excp_badv_o  out  PC_W  bad address of winning lane
retired_cnt_o  out  64  instructions retired since reset

Behaviour:
- Reset (rst=1 at posedge): all lane valid bits cleared; retired_cnt_o=0. All outputs then evaluate to 0 (rf_we_o, dbg_valid_o, excp_flush_o, excp_* fields, rf_* data masked to 0 while invalid).
- Register load:
  - now_allowin_o = !(|lane_valid) || next_allowin_i.
  - On posedge with now_allowin_o=1: lane_valid <= pre_valid_i and bus <= pre_bus_i.
  - If now_allowin_o=0: hold contents.
  - Latency MEM->WB outputs = 1 cycle.
- Flush:
  - If excp_flush_o=1 at a posedge, lane_valid <= 0 and the inputs that cycle are discarded.
  - Flush has priority over load.
  - Flush lasts exactly one cycle per excepting bundle.
- Exception priority:
  - win = lowest index k with lane_valid[k] && excp[k].
  - excp_flush_o = win exists && next_allowin_i.
  - excp_lane_o = k, else 0.
  - excp_pc/ecode/badv_o = lane k fields, else 0.
- Lane masking:
  - retire[j] = lane_valid[j] && next_allowin_i && (no win, or j < win).
  - Lane win itself does not retire: no write, dbg_valid 0.
  - rf_we_o[j] = retire[j] && we[j].
  - dbg_valid_o[j] = retire[j].
- Counter: retired_cnt_o += popcount(retire) each posedge; wraps modulo 2^64. Unaffected by flush except via retire.
- Same-destination writes in one bundle are passed through unaltered; the regfile applies higher lane last.
- Backpressure: next_allowin_i=0 with valid content holds the register, gives zero retire, and suppresses flush; the exception is re-evaluated when next_allowin_i rises.
- Reset mid-stall or mid-flush: rst wins; the register is cleared the same edge.

Test Plan:
- LANES=2, rst for 2 cycles, then idle -> all outputs 0, retired_cnt_o=0, now_allowin_o=1.
- Both lanes valid, we=1, waddr 3/7, wdata 0x11/0x22, no excp, next_allowin_i=1 -> next cycle rf_we_o=2'b11, dbg_valid_o=2'b11, retired_cnt_o increments by 2.
- Lane 0 ok (we=1), lane 1 excp ecode=0x0B, pc=0x1C000004 -> rf_we_o=2'b01, excp_flush_o=1, excp_lane_o=1, excp_pc_o=0x1C000004; following cycle all valid=0 even though pre_valid_i=2'b11; count +1.
- Both lanes excepting (ecodes 0x08 and 0x0B) -> excp_lane_o=0, excp_ecode_o=0x08, rf_we_o=0, count +0.
- next_allowin_i=0 for 3 cycles with lane 0 excepting -> excp_flush_o=0, now_allowin_o=0, register held; when next_allowin_i=1, flush asserts for exactly 1 cycle.
- LANES=4, retired_cnt_o preloaded by forcing to 2^64-2, 4 lanes retire -> wraps to 2; assert rst during a stall -> valid cleared, counter 0 next cycle.
